br_fifo_shared_pstatic_ptr_mgr: RTL and testbench
=================================================

# br_fifo_shared_pstatic_ptr_mgr

Per-logical-FIFO pointer and occupancy manager for the shared pseudo-static multi-FIFO. It consumes the per-FIFO base/bound/size configuration and the configuration-error flag from the size-calculation stage. It arbitrates nothing; it accepts at most one push and one pop per cycle, each addressed to a logical FIFO. It produces shared-RAM write/read addresses and per-FIFO full/empty/item counts.

## Interface
- NumFifos, 2: number of logical FIFOs, ≥1.
- Depth, 8: total shared RAM entries, ≥NumFifos.
- AddrWidth, clamped_clog2(Depth) (localparam): RAM address width.
- CountWidth, $clog2(Depth+1) (localparam): occupancy/size width.
- IdWidth, clamped_clog2(NumFifos) (localparam): FIFO select width.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- config_base  in  NumFifos×AddrWidth  first RAM entry per FIFO; stable after reset.
- config_bound  in  NumFifos×AddrWidth  last RAM entry (inclusive) per FIFO; stable.
- config_size  in  NumFifos×CountWidth  bound−base+1 per FIFO.
- config_error  in  1  misconfiguration flag.
- push_valid / push_ready  in / out  1  push handshake.
- push_fifo_id  in  IdWidth  target FIFO for push.
- pop_valid / pop_ready  in / out  1  pop handshake.
- pop_fifo_id  in  IdWidth  target FIFO for pop.
- ram_wr_valid  out  1  equals push_valid && push_ready.
- ram_wr_addr  out  AddrWidth  write address.
- ram_rd_valid  out  1  equals pop_valid && pop_ready.
- ram_rd_addr  out  AddrWidth  read address.
- full, empty  out  NumFifos  per-FIFO status.
- items  out  NumFifos×CountWidth  per-FIFO occupancy.
- error  out  1  sticky error indication.

## Operation
- FSM states: INIT, ACTIVE, ERROR. Reset enters INIT.
- INIT lasts exactly one cycle. It loads wr_ptr[i]=rd_ptr[i]=config_base[i] and items[i]=0. It goes to ERROR if config_error, else to ACTIVE.
- ACTIVE goes to ERROR when config_error is sampled high.
- ERROR is sticky until rst_n asserts. In ERROR, pointers and counts are frozen.
- push_ready = ACTIVE && !config_error && !full[push_fifo_id]. pop_ready = ACTIVE && !config_error && !empty[pop_fifo_id].
- Readiness uses registered state only. A push to a full FIFO is refused even if the same cycle pops that FIFO. A pop from an empty FIFO is refused even with a same-cycle push (no bypass).
- Accepted push: ram_wr_addr=wr_ptr[id]. wr_ptr advances by 1, wrapping to config_base[id] when it equals config_bound[id].
- Accepted pop: same rule using rd_ptr and ram_rd_addr.
- items[id] is +1 on push and −1 on pop. It is unchanged when push and pop hit the same FIFO in the same cycle. Distinct FIFOs update independently.
- full[i] = items[i]==config_size[i]. empty[i] = items[i]==0.
- Out-of-range push_fifo_id/pop_fifo_id (≥NumFifos) forces the corresponding ready to 0.
- error = (state==ERROR).

## Timing
- Reset values: state=INIT, all pointers 0, items 0, empty all 1, full all 0 (INIT overrides full), push_ready=pop_ready=0, ram_*_valid=0, error=0.
- The RAM address is combinational in the handshake cycle (0-cycle latency). Read data is the consumer's responsibility.
- Pointer, count, full and empty updates are visible the cycle after acceptance.
- The first possible accept is the 2nd rising edge after reset deassertion (cycle after INIT).
- An rst_n assertion mid-operation immediately clears all state, with no draining.

## Structure
- br_fifo_shared_pstatic_pkg holds the state enum (INIT/ACTIVE/ERROR).
- br_fifo_shared_pstatic_ptr_slice is the sub-module, instantiated NumFifos times. It holds one FIFO's wr_ptr/rd_ptr/items with wrap logic. Its inputs are push_hit, pop_hit, init, base, bound and size.
- The top level holds the FSM, ready decode and address muxes.

## Test plan
- NumFifos=2, Depth=8, base={0,4}, bound={3,7}: 4 pushes to FIFO0 → wr_addr 0,1,2,3; full[0]=1; 5th push_ready=0.
- FIFO0 full, then pop 1 and push 1 → rd_addr 0, wr_addr 0 (wrap), items[0]=4.
- Push FIFO1 and pop FIFO0 in the same cycle → both accepted; items[1]+1, items[0]−1.
- Empty FIFO1, push and pop FIFO1 in the same cycle → pop_ready=0, push accepted, items[1]=1.
- config_error=1 in ACTIVE → readies drop the same cycle, error=1 next cycle, and it stays set after config_error falls.
- Assert rst_n low mid-traffic → all items=0 and readies=0 immediately; accepts resume 2 cycles after release.

Source files
------------

// File: rtl/br_fifo_shared_pstatic_pkg.sv
// Shared definitions for the pseudo-static shared multi-FIFO.
// Holds the pointer-manager FSM state encoding and a width helper.
package br_fifo_shared_pstatic_pkg;

    typedef enum logic [1:0] {
        INIT,
        ACTIVE,
        ERROR
    } state_e;

    // $clog2 with a floor of 1 so that single-entry dimensions still get a bit.
    function automatic int clamped_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/br_fifo_shared_pstatic_ptr_slice.sv
// Pointer and occupancy state for one logical FIFO inside the shared RAM.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   init              load pointers from base and clear occupancy
//   push_hit/pop_hit  accepted push/pop addressed to this FIFO
//   base/bound        first/last (inclusive) RAM entry of this FIFO
//   size              capacity of this FIFO
//   wr_ptr/rd_ptr     current write/read RAM addresses
//   items             current occupancy
//   full/empty        occupancy status
module br_fifo_shared_pstatic_ptr_slice #(
    parameter int AddrWidth  = 3,
    parameter int CountWidth = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  push_hit,
    input  logic                  pop_hit,
    input  logic [AddrWidth-1:0]  base,
    input  logic [AddrWidth-1:0]  bound,
    input  logic [CountWidth-1:0] size,
    output logic [AddrWidth-1:0]  wr_ptr,
    output logic [AddrWidth-1:0]  rd_ptr,
    output logic [CountWidth-1:0] items,
    output logic                  full,
    output logic                  empty
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            items  <= '0;
        end else if (init) begin
            wr_ptr <= base;
            rd_ptr <= base;
            items  <= '0;
        end else begin
            if (push_hit) begin
                wr_ptr <= (wr_ptr == bound) ? base : wr_ptr + AddrWidth'(1);
            end
            if (pop_hit) begin
                rd_ptr <= (rd_ptr == bound) ? base : rd_ptr + AddrWidth'(1);
            end
            // Simultaneous push and pop on this FIFO leaves occupancy unchanged.
            unique case ({push_hit, pop_hit})
                2'b10:   items <= items + CountWidth'(1);
                2'b01:   items <= items - CountWidth'(1);
                default: items <= items;
            endcase
        end
    end

    assign full  = (items == size);
    assign empty = (items == '0);

endmodule

// File: rtl/br_fifo_shared_pstatic_ptr_mgr.sv
// Per-logical-FIFO pointer and occupancy manager for the shared pseudo-static
// multi-FIFO. Accepts at most one push and one pop per cycle, each targeting a
// logical FIFO, and produces shared-RAM addresses plus per-FIFO status.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   config_base/bound/size/error       per-FIFO region config and error flag
//   push_valid/ready, push_fifo_id     push handshake and target FIFO
//   pop_valid/ready, pop_fifo_id       pop handshake and target FIFO
//   ram_wr_valid/addr, ram_rd_valid/addr  shared RAM access (same cycle)
//   full, empty, items                 per-FIFO status
//   error                              sticky error indication
module br_fifo_shared_pstatic_ptr_mgr
    import br_fifo_shared_pstatic_pkg::*;
#(
    parameter  int NumFifos   = 2,
    parameter  int Depth      = 8,
    localparam int AddrWidth  = clamped_clog2(Depth),
    localparam int CountWidth = $clog2(Depth + 1),
    localparam int IdWidth    = clamped_clog2(NumFifos)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NumFifos-1:0][AddrWidth-1:0]   config_base,
    input  logic [NumFifos-1:0][AddrWidth-1:0]   config_bound,
    input  logic [NumFifos-1:0][CountWidth-1:0]  config_size,
    input  logic                                 config_error,
    input  logic                                 push_valid,
    output logic                                 push_ready,
    input  logic [IdWidth-1:0]                   push_fifo_id,
    input  logic                                 pop_valid,
    output logic                                 pop_ready,
    input  logic [IdWidth-1:0]                   pop_fifo_id,
    output logic                                 ram_wr_valid,
    output logic [AddrWidth-1:0]                 ram_wr_addr,
    output logic                                 ram_rd_valid,
    output logic [AddrWidth-1:0]                 ram_rd_addr,
    output logic [NumFifos-1:0]                  full,
    output logic [NumFifos-1:0]                  empty,
    output logic [NumFifos-1:0][CountWidth-1:0]  items,
    output logic                                 error
);

    state_e state;

    logic [NumFifos-1:0][AddrWidth-1:0] wr_ptr;
    logic [NumFifos-1:0][AddrWidth-1:0] rd_ptr;
    logic [NumFifos-1:0]                full_int;
    logic [NumFifos-1:0]                push_hit;
    logic [NumFifos-1:0]                pop_hit;
    logic                               init;
    logic                               accepting;
    logic                               sel_full;
    logic                               sel_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            error <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    state <= config_error ? ERROR : ACTIVE;
                    error <= config_error;
                end
                ACTIVE: begin
                    if (config_error) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                    error <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    error <= 1'b0;
                end
            endcase
        end
    end

    assign init      = (state == INIT);
    assign accepting = (state == ACTIVE) && !config_error;

    // Ids that match no FIFO leave the selected status at its refusing default,
    // which is how out-of-range ids get their ready forced low.
    always_comb begin
        sel_full    = 1'b1;
        sel_empty   = 1'b1;
        ram_wr_addr = '0;
        ram_rd_addr = '0;
        for (int unsigned i = 0; i < NumFifos; i++) begin
            if (push_fifo_id == IdWidth'(i)) begin
                sel_full    = full_int[i];
                ram_wr_addr = wr_ptr[i];
            end
            if (pop_fifo_id == IdWidth'(i)) begin
                sel_empty   = empty[i];
                ram_rd_addr = rd_ptr[i];
            end
        end
    end

    assign push_ready   = accepting && !sel_full;
    assign pop_ready    = accepting && !sel_empty;
    assign ram_wr_valid = push_valid && push_ready;
    assign ram_rd_valid = pop_valid && pop_ready;

    // Occupancy is meaningless before the INIT load, so full is held low there.
    assign full = init ? '0 : full_int;

    for (genvar g = 0; g < NumFifos; g++) begin : g_slice
        assign push_hit[g] = ram_wr_valid && (push_fifo_id == IdWidth'(g));
        assign pop_hit[g]  = ram_rd_valid && (pop_fifo_id == IdWidth'(g));

        br_fifo_shared_pstatic_ptr_slice #(
            .AddrWidth  (AddrWidth),
            .CountWidth (CountWidth)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .init     (init),
            .push_hit (push_hit[g]),
            .pop_hit  (pop_hit[g]),
            .base     (config_base[g]),
            .bound    (config_bound[g]),
            .size     (config_size[g]),
            .wr_ptr   (wr_ptr[g]),
            .rd_ptr   (rd_ptr[g]),
            .items    (items[g]),
            .full     (full_int[g]),
            .empty    (empty[g])
        );
    end

endmodule

// File: tb/tb_br_fifo_shared_pstatic_ptr_mgr.sv
// Directed-vector bench for br_fifo_shared_pstatic_ptr_mgr with two FIFOs of
// four entries each (FIFO0 at RAM 0..3, FIFO1 at RAM 4..7).
module tb_br_fifo_shared_pstatic_ptr_mgr;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][2:0] config_base;
    logic [1:0][2:0] config_bound;
    logic [1:0][3:0] config_size;
    logic            config_error;
    logic            push_valid;
    logic            push_ready;
    logic            push_fifo_id;
    logic            pop_valid;
    logic            pop_ready;
    logic            pop_fifo_id;
    logic            ram_wr_valid;
    logic [2:0]      ram_wr_addr;
    logic            ram_rd_valid;
    logic [2:0]      ram_rd_addr;
    logic [1:0]      full;
    logic [1:0]      empty;
    logic [1:0][3:0] items;
    logic            error;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    br_fifo_shared_pstatic_ptr_mgr #(
        .NumFifos (2),
        .Depth    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .config_base  (config_base),
        .config_bound (config_bound),
        .config_size  (config_size),
        .config_error (config_error),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_fifo_id (push_fifo_id),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_fifo_id  (pop_fifo_id),
        .ram_wr_valid (ram_wr_valid),
        .ram_wr_addr  (ram_wr_addr),
        .ram_rd_valid (ram_rd_valid),
        .ram_rd_addr  (ram_rd_addr),
        .full         (full),
        .empty        (empty),
        .items        (items),
        .error        (error)
    );

    // Inputs for the cycle, then the expected combinational outputs and the
    // registered state visible before that cycle's edge.
    typedef struct {
        logic       pv;
        logic       pid;
        logic       ov;
        logic       oid;
        logic       cerr;
        logic       prdy;
        logic       ordy;
        logic [2:0] wa;
        logic [2:0] ra;
        logic [3:0] it0;
        logic [3:0] it1;
        logic [1:0] full;
        logic [1:0] empty;
        logic       err;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //          pv pid ov oid ce  prdy ordy wa ra  it0 it1 full   empty  err
        vecs[0]  = '{1, 0, 0, 0, 0,  0,   0,   0, 0,  0,  0,  2'b00, 2'b11, 0};
        vecs[1]  = '{1, 0, 0, 0, 0,  1,   0,   0, 0,  0,  0,  2'b00, 2'b11, 0};
        vecs[2]  = '{1, 0, 0, 0, 0,  1,   1,   1, 0,  1,  0,  2'b00, 2'b10, 0};
        vecs[3]  = '{1, 0, 0, 0, 0,  1,   1,   2, 0,  2,  0,  2'b00, 2'b10, 0};
        vecs[4]  = '{1, 0, 0, 0, 0,  1,   1,   3, 0,  3,  0,  2'b00, 2'b10, 0};
        vecs[5]  = '{1, 0, 0, 0, 0,  0,   1,   0, 0,  4,  0,  2'b01, 2'b10, 0};
        vecs[6]  = '{0, 0, 1, 0, 0,  0,   1,   0, 0,  4,  0,  2'b01, 2'b10, 0};
        vecs[7]  = '{1, 0, 0, 0, 0,  1,   1,   0, 0,  3,  0,  2'b00, 2'b10, 0};
        vecs[8]  = '{1, 1, 1, 0, 0,  1,   1,   4, 1,  4,  0,  2'b01, 2'b10, 0};
        vecs[9]  = '{0, 0, 0, 1, 0,  1,   1,   0, 0,  3,  1,  2'b00, 2'b00, 0};
        vecs[10] = '{0, 1, 1, 1, 0,  1,   1,   0, 4,  3,  1,  2'b00, 2'b00, 0};
        vecs[11] = '{1, 1, 1, 1, 0,  1,   0,   5, 0,  3,  0,  2'b00, 2'b10, 0};
        vecs[12] = '{1, 1, 1, 1, 0,  1,   1,   6, 5,  3,  1,  2'b00, 2'b00, 0};
        vecs[13] = '{0, 0, 0, 1, 0,  1,   1,   0, 0,  3,  1,  2'b00, 2'b00, 0};
        vecs[14] = '{1, 0, 1, 1, 1,  0,   0,   0, 0,  3,  1,  2'b00, 2'b00, 0};
        vecs[15] = '{1, 0, 1, 1, 0,  0,   0,   0, 0,  3,  1,  2'b00, 2'b00, 1};
        vecs[16] = '{1, 0, 1, 1, 0,  0,   0,   0, 0,  3,  1,  2'b00, 2'b00, 1};

        config_base  = {3'd4, 3'd0};
        config_bound = {3'd7, 3'd3};
        config_size  = {4'd4, 4'd4};
        config_error = 1'b0;
        push_valid   = 1'b0;
        push_fifo_id = 1'b0;
        pop_valid    = 1'b0;
        pop_fifo_id  = 1'b0;
        rst_n        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.items0", items[0], 0);
        chk("rst.items1", items[1], 0);
        chk("rst.empty", empty, 2'b11);
        chk("rst.full", full, 2'b00);
        chk("rst.push_ready", push_ready, 0);
        chk("rst.pop_ready", pop_ready, 0);
        chk("rst.error", error, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            push_valid   = vecs[i].pv;
            push_fifo_id = vecs[i].pid;
            pop_valid    = vecs[i].ov;
            pop_fifo_id  = vecs[i].oid;
            config_error = vecs[i].cerr;
            @(negedge clk);
            chk($sformatf("v%0d.push_ready", i), push_ready, vecs[i].prdy);
            chk($sformatf("v%0d.pop_ready", i), pop_ready, vecs[i].ordy);
            chk($sformatf("v%0d.wr_valid", i), ram_wr_valid, vecs[i].pv & vecs[i].prdy);
            chk($sformatf("v%0d.rd_valid", i), ram_rd_valid, vecs[i].ov & vecs[i].ordy);
            if (vecs[i].pv && vecs[i].prdy)
                chk($sformatf("v%0d.wr_addr", i), ram_wr_addr, vecs[i].wa);
            if (vecs[i].ov && vecs[i].ordy)
                chk($sformatf("v%0d.rd_addr", i), ram_rd_addr, vecs[i].ra);
            chk($sformatf("v%0d.items0", i), items[0], vecs[i].it0);
            chk($sformatf("v%0d.items1", i), items[1], vecs[i].it1);
            chk($sformatf("v%0d.full", i), full, vecs[i].full);
            chk($sformatf("v%0d.empty", i), empty, vecs[i].empty);
            chk($sformatf("v%0d.error", i), error, vecs[i].err);
            @(posedge clk);
            #1;
        end

        // Reset out of ERROR, recover, then reset again mid-traffic.
        config_error = 1'b0;
        push_valid   = 1'b1;
        push_fifo_id = 1'b0;
        pop_valid    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst2.items0", items[0], 0);
        chk("rst2.items1", items[1], 0);
        chk("rst2.error", error, 0);
        chk("rst2.push_ready", push_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rec.init_push_ready", push_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rec.push_ready", push_ready, 1);
        chk("rec.wr_valid", ram_wr_valid, 1);
        chk("rec.wr_addr0", ram_wr_addr, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rec.wr_addr1", ram_wr_addr, 1);
        chk("rec.items0", items[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.items0", items[0], 0);
        chk("mid.push_ready", push_ready, 0);
        chk("mid.wr_valid", ram_wr_valid, 0);
        chk("mid.empty", empty, 2'b11);

        // config_error seen during INIT goes straight to a sticky ERROR.
        push_valid   = 1'b0;
        config_error = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ierr.error_init", error, 0);
        @(posedge clk);
        #1;
        chk("ierr.error", error, 1);
        chk("ierr.push_ready", push_ready, 0);
        config_error = 1'b0;
        @(posedge clk);
        #1;
        chk("ierr.error_sticky", error, 1);
        chk("ierr.pop_ready", pop_ready, 0);
        chk("ierr.push_ready_sticky", push_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
